// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and system-bus-side signal bundle for the sprite-DMA arbiter.
// slave is the arbiter's view; master is the CPU/bus environment's view.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rw;
  logic [7:0]  bus_rdata;
  logic        dma_busy;
  logic        dma_done;

  modport slave (
    input  cpu_addr,
    input  cpu_wdata,
    input  cpu_rw,
    input  bus_rdata,
    output cpu_ready,
    output bus_addr,
    output bus_wdata,
    output bus_rw,
    output dma_busy,
    output dma_done
  );

  modport master (
    output cpu_addr,
    output cpu_wdata,
    output cpu_rw,
    output bus_rdata,
    input  cpu_ready,
    input  bus_addr,
    input  bus_wdata,
    input  bus_rw,
    input  dma_busy,
    input  dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer and 6502 bus arbiter: a CPU write to TRIGGER_ADDR stalls the core and
// copies one page to the PPU OAM data port as alternating read/write bus cycles.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR     = 16'h2004,
  parameter int unsigned XFER_LEN     = 256
) (
  input logic           clk,
  input logic           rst_n,
  oam_dma_ctrl_if.slave io_dma
);

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StAlign,
    StRead,
    StWrite
  } state_e;

  localparam logic [8:0] LastIdx = 9'(XFER_LEN - 1);

  state_e      r_state, w_state_d;
  logic        r_parity;
  logic [7:0]  r_page, w_page_d;
  logic [8:0]  r_idx, w_idx_d;
  logic [7:0]  r_buffer, w_buffer_d;
  logic        r_cpu_ready, w_cpu_ready_d;
  logic        r_dma_busy, w_dma_busy_d;
  logic        r_dma_done, w_dma_done_d;
  logic        w_trigger;

  assign w_trigger = !io_dma.cpu_rw && (io_dma.cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_parity    <= 1'b0;
      r_page      <= 8'h00;
      r_idx       <= 9'd0;
      r_buffer    <= 8'h00;
      r_cpu_ready <= 1'b1;
      r_dma_busy  <= 1'b0;
      r_dma_done  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_parity    <= ~r_parity;
      r_page      <= w_page_d;
      r_idx       <= w_idx_d;
      r_buffer    <= w_buffer_d;
      r_cpu_ready <= w_cpu_ready_d;
      r_dma_busy  <= w_dma_busy_d;
      r_dma_done  <= w_dma_done_d;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_page_d         = r_page;
    w_idx_d          = r_idx;
    w_buffer_d       = r_buffer;
    w_cpu_ready_d    = r_cpu_ready;
    w_dma_busy_d     = r_dma_busy;
    w_dma_done_d     = 1'b0;
    io_dma.bus_addr  = io_dma.cpu_addr;
    io_dma.bus_wdata = io_dma.cpu_wdata;
    io_dma.bus_rw    = io_dma.cpu_rw;

    unique case (r_state)
      StIdle: begin
        // The triggering write itself still reaches the bus through the default mux.
        if (w_trigger) begin
          w_page_d      = io_dma.cpu_wdata;
          w_idx_d       = 9'd0;
          w_state_d     = StHalt;
          w_cpu_ready_d = 1'b0;
          w_dma_busy_d  = 1'b1;
        end
      end
      StHalt: begin
        // Stalled CPU cycle becomes a dummy read; reads must land on parity==0 cycles.
        io_dma.bus_rw = 1'b1;
        w_state_d     = r_parity ? StRead : StAlign;
      end
      StAlign: begin
        io_dma.bus_rw = 1'b1;
        w_state_d     = StRead;
      end
      StRead: begin
        io_dma.bus_addr = {r_page, r_idx[7:0]};
        io_dma.bus_rw   = 1'b1;
        w_buffer_d      = io_dma.bus_rdata;
        w_state_d       = StWrite;
      end
      StWrite: begin
        io_dma.bus_addr  = OAM_ADDR;
        io_dma.bus_wdata = r_buffer;
        io_dma.bus_rw    = 1'b0;
        if (r_idx == LastIdx) begin
          w_state_d     = StIdle;
          w_cpu_ready_d = 1'b1;
          w_dma_busy_d  = 1'b0;
          w_dma_done_d  = 1'b1;
        end else begin
          w_idx_d   = r_idx + 9'd1;
          w_state_d = StRead;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign io_dma.cpu_ready = r_cpu_ready;
  assign io_dma.dma_busy  = r_dma_busy;
  assign io_dma.dma_done  = r_dma_done;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: reset, pass-through, aligned/unaligned transfers,
// mid-transfer reset and a back-to-back trigger on the done cycle.
module tb_oam_dma_ctrl;

  localparam logic [15:0] Trig = 16'h4014;
  localparam logic [15:0] Oam  = 16'h2004;

  logic clk = 1'b0;
  logic rst_n;
  logic m_par;
  int   n_total = 0;
  int   n_bad   = 0;

  oam_dma_ctrl_if dma_if ();

  oam_dma_ctrl u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_dma (dma_if)
  );

  always #5 clk = ~clk;

  // Memory model: byte at any address is its low byte xor 8'hA5.
  assign dma_if.bus_rdata = dma_if.bus_addr[7:0] ^ 8'hA5;

  // Reference clock parity: cleared by reset, toggles every clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_par <= 1'b0;
    else        m_par <= ~m_par;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic [15:0] addr, input logic [7:0] wdata, input logic rw);
    dma_if.cpu_addr  = addr;
    dma_if.cpu_wdata = wdata;
    dma_if.cpu_rw    = rw;
  endtask

  // Called at the drive point of the trigger cycle; returns at the negedge of the last write
  // (or just after the mid-transfer reset when abort_at > 0).
  task automatic do_dma(input logic [7:0] page, input int abort_at, input logic trig_done);
    logic align;
    int   stall;
    set_cpu(Trig, page, 1'b0);
    align = m_par;  // trigger-cycle parity 1 means HALT sees 0, so one ALIGN cycle
    @(negedge clk);
    check_eq("trig_addr", 32'(dma_if.bus_addr), 32'(Trig));
    check_eq("trig_rw", 32'(dma_if.bus_rw), 32'd0);
    check_eq("trig_wdata", 32'(dma_if.bus_wdata), 32'(page));
    check_eq("trig_ready", 32'(dma_if.cpu_ready), 32'd1);
    check_eq("trig_done", 32'(dma_if.dma_done), 32'(trig_done));
    step();
    set_cpu(Trig, 8'hEE, 1'b0);
    @(negedge clk);
    check_eq("halt_addr", 32'(dma_if.bus_addr), 32'(Trig));
    check_eq("halt_rw", 32'(dma_if.bus_rw), 32'd1);
    check_eq("halt_wdata", 32'(dma_if.bus_wdata), 32'hEE);
    check_eq("halt_ready", 32'(dma_if.cpu_ready), 32'd0);
    check_eq("halt_busy", 32'(dma_if.dma_busy), 32'd1);
    stall = 1;
    if (align) begin
      step();
      set_cpu(16'hC123, 8'h77, 1'b0);
      @(negedge clk);
      check_eq("align_addr", 32'(dma_if.bus_addr), 32'hC123);
      check_eq("align_rw", 32'(dma_if.bus_rw), 32'd1);
      check_eq("align_ready", 32'(dma_if.cpu_ready), 32'd0);
      stall++;
    end
    for (int i = 0; i < 256; i++) begin
      step();
      set_cpu(16'hC123, 8'h77, 1'b1);
      @(negedge clk);
      check_eq("rd_addr", 32'(dma_if.bus_addr), 32'({page, 8'(i)}));
      check_eq("rd_rw", 32'(dma_if.bus_rw), 32'd1);
      check_eq("rd_wdata", 32'(dma_if.bus_wdata), 32'h77);
      if (!dma_if.cpu_ready) stall++;
      step();
      @(negedge clk);
      check_eq("wr_addr", 32'(dma_if.bus_addr), 32'(Oam));
      check_eq("wr_rw", 32'(dma_if.bus_rw), 32'd0);
      check_eq("wr_data", 32'(dma_if.bus_wdata), 32'(8'(i) ^ 8'hA5));
      check_eq("wr_done", 32'(dma_if.dma_done), 32'd0);
      if (!dma_if.cpu_ready) stall++;
      if (i + 1 == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("ab_ready", 32'(dma_if.cpu_ready), 32'd1);
        check_eq("ab_busy", 32'(dma_if.dma_busy), 32'd0);
        check_eq("ab_done", 32'(dma_if.dma_done), 32'd0);
        check_eq("ab_addr", 32'(dma_if.bus_addr), 32'hC123);
        check_eq("ab_rw", 32'(dma_if.bus_rw), 32'd1);
        break;
      end
    end
    if (abort_at <= 0) check_eq("stall_len", 32'(stall), align ? 32'd514 : 32'd513);
  endtask

  // Called at the drive point of the first IDLE cycle after a transfer.
  task automatic finish_idle();
    set_cpu(16'h8000, 8'h00, 1'b1);
    @(negedge clk);
    check_eq("done_pulse", 32'(dma_if.dma_done), 32'd1);
    check_eq("done_ready", 32'(dma_if.cpu_ready), 32'd1);
    check_eq("done_busy", 32'(dma_if.dma_busy), 32'd0);
    check_eq("done_addr", 32'(dma_if.bus_addr), 32'h8000);
    check_eq("done_rw", 32'(dma_if.bus_rw), 32'd1);
    step();
    @(negedge clk);
    check_eq("done_clear", 32'(dma_if.dma_done), 32'd0);
    check_eq("idle_ready", 32'(dma_if.cpu_ready), 32'd1);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    set_cpu(16'h1234, 8'h11, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_ready", 32'(dma_if.cpu_ready), 32'd1);
    check_eq("rst_busy", 32'(dma_if.dma_busy), 32'd0);
    check_eq("rst_done", 32'(dma_if.dma_done), 32'd0);
    check_eq("rst_addr", 32'(dma_if.bus_addr), 32'h1234);
    check_eq("rst_rw", 32'(dma_if.bus_rw), 32'd1);

    // Trigger write held while in reset must not start a transfer.
    set_cpu(Trig, 8'h02, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rstlow_ready", 32'(dma_if.cpu_ready), 32'd1);
    check_eq("rstlow_busy", 32'(dma_if.dma_busy), 32'd0);
    check_eq("rstlow_rw", 32'(dma_if.bus_rw), 32'd0);
    set_cpu(16'h8000, 8'h00, 1'b1);
    #2 rst_n = 1'b1;
    step();

    @(negedge clk);
    check_eq("pt_rd_addr", 32'(dma_if.bus_addr), 32'h8000);
    check_eq("pt_rd_rw", 32'(dma_if.bus_rw), 32'd1);
    check_eq("pt_rd_ready", 32'(dma_if.cpu_ready), 32'd1);
    check_eq("pt_rd_busy", 32'(dma_if.dma_busy), 32'd0);
    step();
    set_cpu(16'h0200, 8'h5A, 1'b0);
    @(negedge clk);
    check_eq("pt_wr_addr", 32'(dma_if.bus_addr), 32'h0200);
    check_eq("pt_wr_data", 32'(dma_if.bus_wdata), 32'h5A);
    check_eq("pt_wr_rw", 32'(dma_if.bus_rw), 32'd0);
    check_eq("pt_wr_ready", 32'(dma_if.cpu_ready), 32'd1);
    step();
    set_cpu(16'h8000, 8'h00, 1'b1);
    @(negedge clk);
    check_eq("pt_nodma_ready", 32'(dma_if.cpu_ready), 32'd1);
    check_eq("pt_nodma_busy", 32'(dma_if.dma_busy), 32'd0);
    step();

    // Aligned: trigger on parity 0 so HALT sees parity 1.
    if (m_par) step();
    do_dma(8'h02, 0, 1'b0);
    step();
    finish_idle();

    // Unaligned: trigger on parity 1 so HALT sees parity 0.
    if (!m_par) step();
    do_dma(8'h02, 0, 1'b0);
    step();
    finish_idle();

    // Reset after 100 OAM writes.
    do_dma(8'h02, 100, 1'b0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("ab_hold_ready", 32'(dma_if.cpu_ready), 32'd1);
      check_eq("ab_hold_rw", 32'(dma_if.bus_rw), 32'd1);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge clk);
      check_eq("post_ab_ready", 32'(dma_if.cpu_ready), 32'd1);
      check_eq("post_ab_rw", 32'(dma_if.bus_rw), 32'd1);
    end
    step();
    do_dma(8'h02, 0, 1'b0);
    step();
    finish_idle();

    // Back-to-back: second trigger on the dma_done cycle.
    do_dma(8'h02, 0, 1'b0);
    step();
    do_dma(8'h03, 0, 1'b1);
    step();
    finish_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
